// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xorpar_pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__xorpar_pkg
// Shared types, default parameter values and helpers for the multi-lane
// XOR/parity accumulator.
// Optional feature macro (used by the top level): GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
// -----------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu7t5v0__xorpar_pkg;

    localparam int DEF_WIDTH = 8;   // bits per lane per beat
    localparam int DEF_LANES = 2;   // independent parity lanes
    localparam int DEF_CNTW  = 8;   // beat-counter width (1..32)

    // Input-side framing state: tracks which accepted beat opens a frame.
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } xorpar_state_t;

    // Saturating increment; callers zero-extend their counter and its
    // all-ones ceiling to 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] max);
        return (cnt >= max) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xorpar_reduce.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__xorpar_reduce
// Purely combinational per-lane XOR tree.
//   i_data [LANES*WIDTH-1:0]  lane k = i_data[k*WIDTH +: WIDTH]
//   o_par  [LANES-1:0]        o_par[k] = XOR of all bits of lane k
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__xorpar_reduce
    import gf180mcu_fd_sc_mcu7t5v0__xorpar_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES
)(
    input  logic [LANES*WIDTH-1:0] i_data,
    output logic [LANES-1:0]       o_par
);

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch or
        // loop so that no path can leave it unassigned and infer a latch.
        o_par = '0;
        for (int k = 0; k < LANES; k++) begin
            o_par[k] = ^i_data[k*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xorpar_acc.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__xorpar_acc
// Pipelined multi-lane XOR/parity accumulator over IN_LAST-delimited frames.
// Stage A registers the per-lane reduction of each accepted beat; stage B
// accumulates it and, on the frame's last beat, presents the frame parity
// (even or odd, chosen by ODD on the first beat) and a saturating beat count.
//
// Ports
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   IN_VALID/IN_READY   beat handshake (IN_READY is the only unregistered output)
//   IN_DATA             LANES*WIDTH beat data, lane k = IN_DATA[k*WIDTH +: WIDTH]
//   IN_LAST             final beat of frame
//   ODD                 odd-parity mode, sampled on the frame's first beat
//   IN_EXP              expected parity, sampled with the IN_LAST beat (check build)
//   OUT_VALID/OUT_READY result handshake; outputs hold while stalled
//   OUT_PAR             per-lane frame parity
//   OUT_ERR             OUT_PAR ^ IN_EXP (check build)
//   OUT_BEATS           beats in frame, saturating at 2^CNTW-1
//
// Optional feature macro: GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN adds IN_EXP
// and OUT_ERR; without it those ports and their logic are absent.
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__xorpar_acc
    import gf180mcu_fd_sc_mcu7t5v0__xorpar_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = DEF_LANES,
    parameter int CNTW  = DEF_CNTW
)(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [LANES*WIDTH-1:0] IN_DATA,
    input  logic                   IN_LAST,
    input  logic                   ODD,
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
    input  logic [LANES-1:0]       IN_EXP,
`endif
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [LANES-1:0]       OUT_PAR,
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
    output logic [LANES-1:0]       OUT_ERR,
`endif
    output logic [CNTW-1:0]        OUT_BEATS
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    // ---------------- framing FSM ----------------
    xorpar_state_t r_state;
    xorpar_state_t w_state_n;
    logic          r_odd_f;      // ODD latched on the open frame's first beat

    // ---------------- stage A ----------------
    logic             r_valid_a;
    logic             r_last_a;
    logic [LANES-1:0] r_red_a;
    logic             r_odd_a;   // odd mode travelling with this beat's frame

    // ---------------- stage B ----------------
    logic [LANES-1:0] r_acc;
    logic [CNTW-1:0]  r_cnt;
    logic             r_out_valid;
    logic [LANES-1:0] r_out_par;
    logic [CNTW-1:0]  r_out_beats;

    logic [LANES-1:0] w_red;
    logic             w_in_fire;
    logic             w_b_fire;
    logic             w_odd_beat;
    logic [LANES-1:0] w_acc_n;
    logic [LANES-1:0] w_par_n;
    logic [CNTW-1:0]  w_cnt_n;

`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
    logic [LANES-1:0] r_exp_a;
    logic [LANES-1:0] r_out_err;
`endif

    gf180mcu_fd_sc_mcu7t5v0__xorpar_reduce #(
        .WIDTH (WIDTH),
        .LANES (LANES)
    ) u_reduce (
        .i_data (IN_DATA),
        .o_par  (w_red)
    );

    // Only a finished frame waiting in stage A behind an unconsumed result
    // blocks the input; partial-frame beats in stage A can always drain.
    assign IN_READY   = !(r_valid_a && r_last_a && r_out_valid && !OUT_READY);
    assign w_in_fire  = IN_VALID && IN_READY;
    assign w_b_fire   = r_valid_a && IN_READY;
    // The first beat of a frame takes ODD directly; later beats reuse the
    // latched value so a change on ODD mid-frame has no effect.
    assign w_odd_beat = (r_state == S_IDLE) ? ODD : r_odd_f;

    assign w_acc_n = r_acc ^ r_red_a;
    assign w_par_n = w_acc_n ^ {LANES{r_odd_a}};
    assign w_cnt_n = CNTW'(sat_inc(32'(r_cnt), 32'(CNT_MAX)));

    // ---------------- framing FSM ----------------
    always_ff @(posedge CLK) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (RST) begin
            r_state <= S_IDLE;
            r_odd_f <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_in_fire && (r_state == S_IDLE)) begin
                r_odd_f <= ODD;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (w_in_fire && !IN_LAST) w_state_n = S_FRAME;
            S_FRAME: if (w_in_fire &&  IN_LAST) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // ---------------- stage A ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid_a <= 1'b0;
            r_last_a  <= 1'b0;
            r_red_a   <= '0;
            r_odd_a   <= 1'b0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
            r_exp_a   <= '0;
`endif
        end else if (IN_READY) begin
            r_valid_a <= IN_VALID;
            if (IN_VALID) begin
                r_red_a  <= w_red;
                r_last_a <= IN_LAST;
                r_odd_a  <= w_odd_beat;
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
                r_exp_a  <= IN_EXP;
`endif
            end
        end
    end

    // ---------------- stage B ----------------
    // A load only happens when IN_READY is high, which already guarantees the
    // previous result is absent or retiring this edge, so the output hold
    // needs no extra term and a retire plus load in one cycle leaves no bubble.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_par   <= '0;
            r_out_beats <= '0;
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
            r_out_err   <= '0;
`endif
        end else begin
            if (r_out_valid && OUT_READY) begin
                r_out_valid <= 1'b0;
            end
            if (w_b_fire) begin
                if (r_last_a) begin
                    r_out_par   <= w_par_n;
                    r_out_beats <= w_cnt_n;
                    r_out_valid <= 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
                    r_out_err   <= w_par_n ^ r_exp_a;
`endif
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_acc_n;
                    r_cnt <= w_cnt_n;
                end
            end
        end
    end

    assign OUT_VALID = r_out_valid;
    assign OUT_PAR   = r_out_par;
    assign OUT_BEATS = r_out_beats;
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
    assign OUT_ERR   = r_out_err;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xorpar_acc.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu7t5v0__xorpar_acc
// Scoreboard bench: the driver feeds beats into a frame-level reference model
// (bit counts per lane, beat count, first-beat ODD) and pushes the expected
// result when a frame's last beat is accepted; an independent monitor pops
// and compares on every output handshake and checks output hold under stall.
// Built with CNTW=4 so saturation is reachable with short frames.
// Honours GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN for IN_EXP/OUT_ERR.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu7t5v0__xorpar_acc;

    localparam int WIDTH = 8;
    localparam int LANES = 2;
    localparam int CNTW  = 4;
    localparam int CMAX  = (1 << CNTW) - 1;

    logic                   CLK = 1'b0;
    logic                   RST;
    logic                   IN_VALID;
    logic                   IN_READY;
    logic [LANES*WIDTH-1:0] IN_DATA;
    logic                   IN_LAST;
    logic                   ODD;
    logic [LANES-1:0]       IN_EXP;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic [LANES-1:0]       OUT_PAR;
    logic [LANES-1:0]       OUT_ERR;
    logic [CNTW-1:0]        OUT_BEATS;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__xorpar_acc #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .CNTW  (CNTW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .IN_LAST   (IN_LAST),
        .ODD       (ODD),
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
        .IN_EXP    (IN_EXP),
`endif
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_PAR   (OUT_PAR),
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
        .OUT_ERR   (OUT_ERR),
`endif
        .OUT_BEATS (OUT_BEATS)
    );

`ifndef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
    assign OUT_ERR = '0;
`endif

    typedef struct {
        logic [LANES-1:0] par;
        logic [CNTW-1:0]  beats;
        logic [LANES-1:0] err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   bp_mode;        // 0: OUT_READY low, 1: high, 2: random

    // frame-level reference model
    int   m_ones [LANES];
    int   m_beats;
    bit   m_odd;
    bit   m_open;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, need %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_beat(input logic [LANES*WIDTH-1:0] data, input logic last,
                              input logic odd, input logic [LANES-1:0] exp);
        exp_t e;
        if (!m_open) begin
            m_open  = 1'b1;
            m_odd   = odd;
            m_beats = 0;
            for (int k = 0; k < LANES; k++) m_ones[k] = 0;
        end
        for (int k = 0; k < LANES; k++) m_ones[k] += $countones(data[k*WIDTH +: WIDTH]);
        m_beats++;
        if (last) begin
            for (int k = 0; k < LANES; k++) e.par[k] = ((m_ones[k] % 2) == 1) ^ m_odd;
            e.beats = CNTW'((m_beats > CMAX) ? CMAX : m_beats);
            e.err   = e.par ^ exp;
            sb.push_back(e);
            m_open = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_beat(input logic [LANES*WIDTH-1:0] data, input logic last,
                             input logic odd, input logic [LANES-1:0] exp);
        int waited = 0;
        IN_VALID = 1'b1;
        IN_DATA  = data;
        IN_LAST  = last;
        ODD      = odd;
        IN_EXP   = exp;
        forever begin
            @(negedge CLK);
            if (IN_READY) break;
            waited++;
            if (waited > 300) begin
                check("in_ready_timeout", 32'(IN_READY), 32'd1);
                IN_VALID = 1'b0;
                @(posedge CLK);
                #1;
                return;
            end
        end
        model_beat(data, last, odd, exp);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge CLK);
            t++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        @(negedge CLK);
        check({tag, "_out_valid"}, 32'(OUT_VALID), 32'd0);
        check({tag, "_out_par"},   32'(OUT_PAR),   32'd0);
        check({tag, "_out_beats"}, 32'(OUT_BEATS), 32'd0);
        check({tag, "_in_ready"},  32'(IN_READY),  32'd1);
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
        check({tag, "_out_err"},   32'(OUT_ERR),   32'd0);
`endif
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST    = 1'b0;
        m_open = 1'b0;     // partial frame is discarded by the DUT
    endtask

    // result-ready driver
    initial begin
        OUT_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (bp_mode)
                0:       OUT_READY = 1'b0;
                1:       OUT_READY = 1'b1;
                default: OUT_READY = ($urandom_range(99) < 60);
            endcase
        end
    end

    // monitor: compares on handshake, checks hold while stalled
    bit               hold_pend = 1'b0;
    logic [LANES-1:0] hold_par;
    logic [LANES-1:0] hold_err;
    logic [CNTW-1:0]  hold_beats;

    always @(negedge CLK) begin
        if (RST) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 32'(OUT_VALID), 32'd1);
                check("hold_par",   32'(OUT_PAR),   32'(hold_par));
                check("hold_beats", 32'(OUT_BEATS), 32'(hold_beats));
                check("hold_err",   32'(OUT_ERR),   32'(hold_err));
            end
            hold_pend  = OUT_VALID && !OUT_READY;
            hold_par   = OUT_PAR;
            hold_beats = OUT_BEATS;
            hold_err   = OUT_ERR;
            if (OUT_VALID && OUT_READY) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(OUT_VALID), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_par",   32'(OUT_PAR),   32'(e.par));
                    check("out_beats", 32'(OUT_BEATS), 32'(e.beats));
`ifdef GF180MCU_FD_SC_MCU7T5V0_XORPAR_CHECK_EN
                    check("out_err",   32'(OUT_ERR),   32'(e.err));
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES*WIDTH-1:0] d;
        int                     len;
        RST      = 1'b1;
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        IN_LAST  = 1'b0;
        ODD      = 1'b0;
        IN_EXP   = '0;
        bp_mode  = 1;
        m_open   = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        reset_checks("reset");

        // single beat, even parity: lane0 0x03 -> 0, lane1 0x01 -> 1
        send_beat(16'h0103, 1'b1, 1'b0, 2'b11);
        // three beats, odd mode set only on the first beat
        send_beat(16'h0001, 1'b0, 1'b1, 2'b00);
        send_beat(16'h0001, 1'b0, 1'b0, 2'b00);
        send_beat(16'h0001, 1'b1, 1'b0, 2'b00);
        drain();

        // backpressure: two single-beat frames against a stalled output
        bp_mode = 0;
        idle(1);
        send_beat(16'h00ff, 1'b1, 1'b0, 2'b01);
        send_beat(16'h0107, 1'b1, 1'b1, 2'b10);
        idle(3);
        @(negedge CLK);
        check("stall_in_ready",  32'(IN_READY),  32'd0);
        check("stall_out_valid", 32'(OUT_VALID), 32'd1);
        @(posedge CLK);
        #1;
        bp_mode = 1;
        drain();

        // saturation: 20 zero beats with a 4-bit counter
        for (int i = 0; i < 20; i++) send_beat('0, (i == 19), 1'b0, 2'b00);
        drain();

        // reset in mid-frame, then a clean single-beat frame
        send_beat('0, 1'b0, 1'b1, 2'b00);
        send_beat('0, 1'b0, 1'b0, 2'b00);
        do_reset();
        reset_checks("midframe_reset");
        send_beat('0, 1'b1, 1'b0, 2'b00);
        drain();

        // random frames, random gaps, random result backpressure
        bp_mode = 2;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(20, 1);
            for (int b = 0; b < len; b++) begin
                d = LANES*WIDTH'($urandom);
                send_beat(d, (b == len - 1), 1'($urandom), LANES'($urandom));
                if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
            end
        end
        drain();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
